data_sram_ctrl: RTL and testbench
=================================

DATA_SRAM_CTRL -- requirements
Module: data_sram_ctrl

Interface
REQ-001 Parameters: none; widths fixed at 32-bit address/data, 4-bit byte strobe.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  MEM-stage access request this cycle.
REQ-005 req_op  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 SW, 110 SB, 111 SH.
REQ-006 req_addr  in  32  byte address of the access.
REQ-007 req_wdata  in  32  store data, right-aligned.
REQ-008 req_ready  out  1  controller can accept a request.
REQ-009 stallreq  out  1  pipeline stall request while an access is in flight.
REQ-010 sram_req, sram_wr  out  1,1  bus request and write flag.
REQ-011 sram_size  out  2  0 byte, 1 half, 2 word.
REQ-012 sram_addr, sram_wdata  out  32,32  bus address and lane-replicated store data.
REQ-013 sram_wstrb  out  4  byte write strobes.
REQ-014 sram_addr_ok, sram_data_ok  in  1,1  bus address accept, bus data/write completion.
REQ-015 sram_rdata  in  32  raw bus read word.
REQ-016 resp_valid  out  1  one-cycle completion pulse.
REQ-017 resp_rdata  out  32  aligned, extended load result; 0 for stores.
REQ-018 resp_excp  out  1  misaligned-address exception, valid with resp_valid.

Function
REQ-019 FSM states: IDLE, REQ, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 IDLE with req_valid: latch op/addr/wdata; misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> RESP with excp=1, no bus access; otherwise -> REQ.
REQ-021 REQ: sram_req=1 with latched fields held stable; on addr_ok and data_ok same cycle -> RESP; on addr_ok alone -> WAIT; else stay REQ.
REQ-022 WAIT: sram_req=0; on data_ok -> RESP, capturing sram_rdata.
REQ-023 RESP: resp_valid=1 for exactly one cycle, then IDLE; new request accepted no earlier than next IDLE cycle.
REQ-024 stallreq SHALL be 1 in IDLE when req_valid=1, and in REQ and WAIT; 0 in RESP and otherwise.
REQ-025 sram_size: LB/LBU/SB 0, LH/LHU/SH 1, LW/SW 2; sram_wr=1 only for SW/SB/SH.
REQ-026 sram_wstrb: SW 1111; SB 0001<<addr[1:0]; SH 0011 (addr[1]=0) or 1100 (addr[1]=1); loads 0000.
REQ-027 sram_wdata: SW as-is; SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; loads 0.
REQ-028 Load data: byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-029 resp_rdata SHALL be registered and held until next response; resp_excp=1 forces resp_rdata=0.
REQ-030 sram_addr_ok/sram_data_ok in IDLE or RESP SHALL be ignored (stale completion after reset).
REQ-031 Outside REQ, sram_req=0; sram_addr/size/wstrb/wdata SHALL be 0 in IDLE.

Reset
REQ-032 rst=1 SHALL immediately force IDLE, req_ready=1, stallreq=0, sram_req=0, sram_wr=0, sram_wstrb=0, resp_valid=0, resp_excp=0, resp_rdata=0, all latched fields 0, including mid-transaction.
REQ-033 After rst deassertion the first request SHALL be accepted in the first IDLE cycle with req_valid=1.

Verification
REQ-034 LB addr 0x1002, addr_ok cycle 1, data_ok cycle 3, rdata 0x12C45678 -> size 0, wstrb 0000, resp_rdata 0xFFFFFFC4 one cycle after data_ok, stallreq high 4 cycles.
REQ-035 SH addr 0x2002 wdata 0x0000BEEF, addr_ok and data_ok same cycle -> wstrb 1100, sram_wdata 0xBEEFBEEF, resp_valid next cycle, resp_rdata 0.
REQ-036 LW addr 0x3001 -> no sram_req, resp_valid+resp_excp one cycle after accept; LHU addr 0x3002 rdata 0x8001FFFF -> 0x00008001.
REQ-037 addr_ok withheld 5 cycles -> sram_req and all bus fields stable each cycle, stallreq stays 1, req_ready 0.
REQ-038 rst pulsed while in WAIT, then data_ok arrives in IDLE -> all outputs reset values, no resp_valid, next LW completes normally.

Source files
------------

// File: rtl/data_sram_ctrl.sv
// MEM-stage data SRAM controller: one outstanding load/store on an addr_ok/data_ok
// bus, with sub-word lane steering, load extension and misalignment exceptions.
module data_sram_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        stallreq,
  output logic        sram_req,
  output logic        sram_wr,
  output logic [1:0]  sram_size,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  output logic [3:0]  sram_wstrb,
  input  logic        sram_addr_ok,
  input  logic        sram_data_ok,
  input  logic [31:0] sram_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_excp
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        excp_q;

  logic        accept, req_misalign;
  logic        cap_rdata, cap_zero;
  logic        is_store;
  logic        busy;
  logic [1:0]  size_d;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d, load_d;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Alignment check on the incoming request, before anything is latched
  always_comb begin
    req_misalign = 1'b0;
    case (req_op)
      OP_LW, OP_SW:         req_misalign = |req_addr[1:0];
      OP_LH, OP_LHU, OP_SH: req_misalign = req_addr[0];
      default:              req_misalign = 1'b0;
    endcase
  end

  // FSM next state; bus handshakes are only honoured in REQ and WAIT
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    cap_rdata = 1'b0;
    cap_zero  = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        accept = 1'b1;
        if (req_misalign) begin
          state_nxt = RESP;
          cap_zero  = 1'b1;
        end else begin
          state_nxt = REQ;
        end
      end
      REQ: if (sram_addr_ok && sram_data_ok) begin
        state_nxt = RESP;
        cap_rdata = 1'b1;
      end else if (sram_addr_ok) begin
        state_nxt = WAIT;
      end
      WAIT: if (sram_data_ok) begin
        state_nxt = RESP;
        cap_rdata = 1'b1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      excp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        excp_q  <= req_misalign;
      end
      if (cap_zero)
        rdata_q <= '0;
      else if (cap_rdata)
        rdata_q <= is_store ? 32'h0 : load_d;
    end
  end

  assign is_store = (op_q == OP_SW) || (op_q == OP_SB) || (op_q == OP_SH);

  // Bus field decode from the latched request
  always_comb begin
    size_d  = 2'd2;
    wstrb_d = 4'b0000;
    wdata_d = 32'h0;
    case (op_q)
      OP_LB, OP_LBU: size_d = 2'd0;
      OP_LH, OP_LHU: size_d = 2'd1;
      OP_SW: begin
        size_d  = 2'd2;
        wstrb_d = 4'b1111;
        wdata_d = wdata_q;
      end
      OP_SB: begin
        size_d  = 2'd0;
        wdata_d = {4{wdata_q[7:0]}};
        case (addr_q[1:0])
          2'd0:    wstrb_d = 4'b0001;
          2'd1:    wstrb_d = 4'b0010;
          2'd2:    wstrb_d = 4'b0100;
          default: wstrb_d = 4'b1000;
        endcase
      end
      OP_SH: begin
        size_d  = 2'd1;
        wdata_d = {2{wdata_q[15:0]}};
        wstrb_d = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: size_d = 2'd2;
    endcase
  end

  // Load lane select and extension from the raw bus word
  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_b = sram_rdata[7:0];
      2'd1:    lane_b = sram_rdata[15:8];
      2'd2:    lane_b = sram_rdata[23:16];
      default: lane_b = sram_rdata[31:24];
    endcase
    lane_h = addr_q[1] ? sram_rdata[31:16] : sram_rdata[15:0];
    case (op_q)
      OP_LB:   load_d = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  load_d = {24'h0, lane_b};
      OP_LH:   load_d = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  load_d = {16'h0, lane_h};
      OP_LW:   load_d = sram_rdata;
      default: load_d = 32'h0;
    endcase
  end

  assign busy       = (state != IDLE);
  assign req_ready  = (state == IDLE);
  assign stallreq   = ((state == IDLE) && req_valid) || (state == REQ) || (state == WAIT);
  assign sram_req   = (state == REQ);
  assign sram_wr    = busy && is_store;
  assign sram_size  = busy ? size_d  : 2'd0;
  assign sram_addr  = busy ? addr_q  : 32'h0;
  assign sram_wstrb = busy ? wstrb_d : 4'b0000;
  assign sram_wdata = busy ? wdata_d : 32'h0;
  assign resp_valid = (state == RESP);
  assign resp_excp  = (state == RESP) && excp_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Bench for data_sram_ctrl: directed scenarios then randomized transactions,
// each checked against a lane/extension model computed from the access rules.
module tb_data_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, stallreq;
  logic        sram_req, sram_wr;
  logic [1:0]  sram_size;
  logic [31:0] sram_addr, sram_wdata;
  logic [3:0]  sram_wstrb;
  logic        sram_addr_ok, sram_data_ok;
  logic [31:0] sram_rdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_excp;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_resp = 32'h0;

  data_sram_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .stallreq(stallreq),
    .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wstrb(sram_wstrb),
    .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_excp(resp_excp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---- reference model (from the access rules) ----
  function automatic bit m_store(input logic [2:0] op);
    return op >= 3'd5;
  endfunction

  function automatic int m_bytes(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd5) return 4;
    if (op == 3'd3 || op == 3'd4 || op == 3'd7) return 2;
    return 1;
  endfunction

  function automatic bit m_misalign(input logic [2:0] op, input logic [31:0] a);
    return (a % m_bytes(op)) != 0;
  endfunction

  function automatic logic [1:0] m_size(input logic [2:0] op);
    return (m_bytes(op) == 4) ? 2'd2 : (m_bytes(op) == 2) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [2:0] op, input logic [31:0] a);
    int n;
    logic [3:0] ones;
    if (!m_store(op)) return 4'b0000;
    n = m_bytes(op);
    ones = 4'((1 << n) - 1);
    return 4'(ones << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] w);
    if (!m_store(op)) return 32'h0;
    if (m_bytes(op) == 1) return (w & 32'hFF) * 32'h01010101;
    if (m_bytes(op) == 2) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] r);
    logic [31:0] v;
    int n;
    if (m_store(op)) return 32'h0;
    n = m_bytes(op);
    if (n == 4) return r;
    v = (r >> (8 * (a % 4))) & ((n == 1) ? 32'hFF : 32'hFFFF);
    if (op == 3'd1 && v >= 32'h80)   v = v - 32'h100;
    if (op == 3'd3 && v >= 32'h8000) v = v - 32'h10000;
    return v;
  endfunction

  // One full transaction. a_dly: REQ cycles before addr_ok; same: data_ok with addr_ok;
  // d_dly: WAIT cycles before data_ok.
  task automatic do_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int a_dly, input int d_dly,
                        input bit same, input bit noise);
    int stalls = 0;
    int exp_stalls;
    logic [31:0] exp_r;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    sram_addr_ok = noise & 1'($urandom); sram_data_ok = noise & 1'($urandom);
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_sram_req", 32'(sram_req), 32'd0);
    chk("idle_addr", sram_addr, 32'h0);
    chk("idle_rvalid", 32'(resp_valid), 32'd0);
    chk("held_rdata", resp_rdata, last_resp);
    stalls += int'(stallreq);
    @(posedge clk); #1;
    req_valid = 1'($urandom); req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    sram_addr_ok = 1'b0; sram_data_ok = 1'b0;
    if (m_misalign(op, addr)) begin
      @(negedge clk);
      chk("excp_valid", 32'(resp_valid), 32'd1);
      chk("excp_flag", 32'(resp_excp), 32'd1);
      chk("excp_rdata", resp_rdata, 32'h0);
      chk("excp_no_req", 32'(sram_req), 32'd0);
      chk("excp_stall", 32'(stallreq), 32'd0);
      chk("excp_stall_cnt", 32'(stalls), 32'd1);
      last_resp = 32'h0;
      @(posedge clk); #1; req_valid = 1'b0;
      return;
    end
    for (int c = 0; c <= a_dly; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      req_valid = 1'b0;
      sram_addr_ok = (c == a_dly);
      sram_data_ok = (c == a_dly) && same;
      sram_rdata = sram_data_ok ? rdata : $urandom;
      @(negedge clk);
      chk("req_sram_req", 32'(sram_req), 32'd1);
      chk("req_ready", 32'(req_ready), 32'd0);
      chk("req_wr", 32'(sram_wr), 32'(m_store(op)));
      chk("req_size", 32'(sram_size), 32'(m_size(op)));
      chk("req_addr", sram_addr, addr);
      chk("req_wstrb", 32'(sram_wstrb), 32'(m_wstrb(op, addr)));
      chk("req_wdata", sram_wdata, m_wdata(op, wdata));
      stalls += int'(stallreq);
    end
    if (!same) begin
      for (int k = 0; k <= d_dly; k++) begin
        @(posedge clk); #1;
        sram_addr_ok = 1'b0;
        sram_data_ok = (k == d_dly);
        sram_rdata = sram_data_ok ? rdata : $urandom;
        @(negedge clk);
        chk("wait_sram_req", 32'(sram_req), 32'd0);
        chk("wait_rvalid", 32'(resp_valid), 32'd0);
        stalls += int'(stallreq);
      end
    end
    @(posedge clk); #1;
    sram_addr_ok = noise & 1'($urandom); sram_data_ok = noise & 1'($urandom);
    sram_rdata = $urandom;
    exp_r = m_load(op, addr, rdata);
    exp_stalls = 1 + (a_dly + 1) + (same ? 0 : d_dly + 1);
    @(negedge clk);
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_excp", 32'(resp_excp), 32'd0);
    chk("resp_rdata", resp_rdata, exp_r);
    chk("resp_stall", 32'(stallreq), 32'd0);
    chk("stall_cnt", 32'(stalls), 32'(exp_stalls));
    last_resp = exp_r;
    @(posedge clk); #1;
    req_valid = 1'b0; sram_addr_ok = 1'b0; sram_data_ok = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_stall"}, 32'(stallreq), 32'd0);
    chk({tag, "_sreq"}, 32'(sram_req), 32'd0);
    chk({tag, "_wr"}, 32'(sram_wr), 32'd0);
    chk({tag, "_wstrb"}, 32'(sram_wstrb), 32'd0);
    chk({tag, "_addr"}, sram_addr, 32'h0);
    chk({tag, "_rvalid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_rexcp"}, 32'(resp_excp), 32'd0);
    chk({tag, "_rdata"}, resp_rdata, 32'h0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    sram_addr_ok = 1'b0; sram_data_ok = 1'b0; sram_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("reset");
    @(negedge clk); rst = 1'b0;

    // LB 0x1002: addr_ok first REQ cycle, data_ok two cycles later
    do_txn(3'd1, 32'h1002, 32'h0, 32'h12C45678, 0, 1, 1'b0, 1'b0);
    // SH 0x2002 with both handshakes together
    do_txn(3'd7, 32'h2002, 32'h0000BEEF, 32'hDEADBEEF, 0, 0, 1'b1, 1'b0);
    // Misaligned LW, then LHU upper half
    do_txn(3'd0, 32'h3001, 32'h0, 32'h0, 0, 0, 1'b1, 1'b0);
    do_txn(3'd4, 32'h3002, 32'h0, 32'h8001FFFF, 0, 0, 1'b1, 1'b0);
    // addr_ok withheld 5 cycles on a store
    do_txn(3'd6, 32'h4003, 32'h000000A5, 32'h0, 5, 2, 1'b0, 1'b0);

    // Reset while in WAIT; stale data_ok afterwards must be ignored
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 3'd0; req_addr = 32'h5000;
    @(posedge clk); #1;
    req_valid = 1'b0; sram_addr_ok = 1'b1;
    @(posedge clk); #1;
    sram_addr_ok = 1'b0;
    @(negedge clk);
    chk("pre_rst_wait_stall", 32'(stallreq), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0; sram_data_ok = 1'b1; sram_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("stale_rvalid", 32'(resp_valid), 32'd0);
    chk("stale_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    sram_data_ok = 1'b0;
    @(negedge clk);
    chk("stale_rvalid2", 32'(resp_valid), 32'd0);
    last_resp = 32'h0;
    do_txn(3'd0, 32'h5000, 32'h0, 32'h13579BDF, 1, 0, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      op = 3'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = (m_bytes(op) == 4) ? 2'd0 :
                                              (m_bytes(op) == 2) ? {a[1], 1'b0} : a[1:0];
      do_txn(op, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
